// File: rtl/keypad_pkg.sv
// State encoding, default timing and helpers shared by the keypad scanner and its bench.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } scan_state_e;

  localparam int DEF_ROWS        = 4;
  localparam int DEF_COLS        = 4;
  localparam int DEF_DWELL_CYC   = 50000;
  localparam int DEF_DB_CYC      = 500000;
  localparam int DEF_RPT_DLY_CYC = 25000000;
  localparam int DEF_RPT_PER_CYC = 5000000;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Key-event queue: registered storage, head visible same cycle, one push and one pop per clock.
// Backpressure: a push into a full queue is ignored unless a pop happens in the same clock.
module key_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Scans a row/column keypad, debounces one key at a time and queues key codes (plus auto-repeats).
// Events appear DB_CYC clocks after the detecting scan sample; a full queue drops new events and flags overflow.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int DWELL_CYC   = DEF_DWELL_CYC,
  parameter int DB_CYC      = DEF_DB_CYC,
  parameter int RPT_DLY_CYC = DEF_RPT_DLY_CYC,
  parameter int RPT_PER_CYC = DEF_RPT_PER_CYC,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               row,
  input  logic                          repeat_en,
  output logic [COLS-1:0]               col,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic                          overflow
);

  localparam int KW  = $clog2(ROWS*COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int DWW = cnt_w(DWELL_CYC);
  localparam int DBW = cnt_w(DB_CYC);
  localparam int RPW = cnt_w((RPT_DLY_CYC > RPT_PER_CYC) ? RPT_DLY_CYC : RPT_PER_CYC);

  logic [ROWS-1:0] row_s1_q, row_s2_q;
  scan_state_e     state_q, state_d;
  logic [CW-1:0]   col_idx_q, col_idx_d, col_next;
  logic [RW-1:0]   row_lat_q, row_lat_d, low_idx;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0]  db_q, db_d;
  logic [RPW-1:0]  rpt_q, rpt_d;
  logic            rpt_first_q, rpt_first_d;
  logic            held_q, held_d;
  logic            ovf_q, ovf_d;
  logic [COLS-1:0] col_q, col_d;
  logic [3:0]      low_cnt;
  logic            all_high, lat_only, rpt_hit;
  logic            push, pop, fifo_full, fifo_empty;
  logic [KW-1:0]   push_code;

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!row_s2_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        low_idx = RW'(i);
      end
    end
  end

  assign all_high  = &row_s2_q;
  assign lat_only  = (row_s2_q == ~(ROWS'(1) << row_lat_q));
  assign col_next  = (col_idx_q == CW'(COLS-1)) ? '0 : col_idx_q + CW'(1);
  assign rpt_hit   = rpt_first_q ? (rpt_q == RPW'(RPT_DLY_CYC-1)) : (rpt_q == RPW'(RPT_PER_CYC-1));
  assign push_code = KW'(int'(row_lat_q) * COLS + int'(col_idx_q));

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_lat_d   = row_lat_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    held_d      = held_q;
    push        = 1'b0;
    case (state_q)
      ST_SCAN: begin
        // col_q is all ones only in the clock after reset; column 0 gets a full dwell from there.
        if (&col_q) begin
          dwell_d = '0;
        end else if (dwell_q == DWW'(DWELL_CYC-1)) begin
          dwell_d = '0;
          if (low_cnt == 4'd1) begin
            row_lat_d = low_idx;
            db_d      = '0;
            state_d   = ST_DB_PRESS;
          end else begin
            col_idx_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + DWW'(1);
        end
      end
      ST_DB_PRESS: begin
        if (!lat_only) begin
          state_d   = ST_SCAN;
          col_idx_d = col_next;
          dwell_d   = '0;
        end else if (db_q == DBW'(DB_CYC-1)) begin
          push        = 1'b1;
          held_d      = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
          state_d     = ST_HELD;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      ST_HELD: begin
        if (all_high) begin
          db_d    = '0;
          state_d = ST_DB_RELEASE;
        end else if (!repeat_en) begin
          rpt_d       = '0;
          rpt_first_d = 1'b1;
        end else if (rpt_hit) begin
          push        = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + RPW'(1);
        end
      end
      ST_DB_RELEASE: begin
        // Repeat timer is frozen here so a bounce back to HELD resumes where it left off.
        if (!row_s2_q[row_lat_q]) begin
          state_d = ST_HELD;
        end else if (!all_high) begin
          db_d = '0;
        end else if (db_q == DBW'(DB_CYC-1)) begin
          held_d    = 1'b0;
          col_idx_d = col_next;
          dwell_d   = '0;
          state_d   = ST_SCAN;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
    col_d = ~(COLS'(1) << col_idx_d);
  end

  assign pop   = key_valid && key_ready;
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      state_q     <= ST_SCAN;
      col_idx_q   <= '0;
      row_lat_q   <= '0;
      dwell_q     <= '0;
      db_q        <= '0;
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
      held_q      <= 1'b0;
      ovf_q       <= 1'b0;
      col_q       <= '1;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_lat_q   <= row_lat_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
      held_q      <= held_d;
      ovf_q       <= ovf_d;
      col_q       <= col_d;
    end
  end

  key_event_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_code),
    .pop      (pop),
    .pop_dat  (key_code),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign key_valid = !fifo_empty;
  assign key_held  = held_q;
  assign overflow  = ovf_q;
  assign col       = col_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with shortened timing (dwell 4, debounce 8, repeat 32/16).
module tb_matrix_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'b1111;
  logic       repeat_en = 1'b0;
  logic       key_ready = 1'b0;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_keypad_scanner #(
    .ROWS        (4),
    .COLS        (4),
    .DWELL_CYC   (4),
    .DB_CYC      (8),
    .RPT_DLY_CYC (32),
    .RPT_PER_CYC (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .repeat_en (repeat_en),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  typedef struct {
    logic       rst;
    logic [3:0] row;
    logic [3:0] exp_col;
    logic       exp_valid;
    logic       exp_held;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns on the first clock in which column c is driven low.
  task automatic wait_col(input int c);
    int n;
    logic [3:0] tgt;
    tgt = ~(4'b0001 << c);
    n = 0;
    while (col == tgt && n < 100) begin tick(); n++; end
    while (col != tgt && n < 200) begin tick(); n++; end
    total++;
    if (col != tgt) begin
      bad++;
      $display("FAIL wait_col%0d: col=%b, expected %b within 200 clocks", c, col, tgt);
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    wait_col(c);
    row = ~(4'b0001 << r);
    repeat (hold) tick();
    row = 4'b1111;
    repeat (14) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[19];
    int   ev_t[8];
    int   ev_code0;
    int   nev;
    int   exp_codes[4];

    vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0};
    exp_codes[0] = 1;
    exp_codes[1] = 6;
    exp_codes[2] = 11;
    exp_codes[3] = 12;

    // Reset state and idle scan sequence.
    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      row = vecs[i].row;
      tick();
      check($sformatf("vec%0d_col", i),   32'(col),       32'(vecs[i].exp_col));
      check($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_held", i),  32'(key_held),  32'(vecs[i].exp_held));
      if (vecs[i].rst) check($sformatf("vec%0d_ovf", i), 32'(overflow), 0);
    end

    // Single press at row 1, column 2: code 6.
    wait_col(2);
    row = 4'b1101;
    repeat (20) tick();
    check("press_held",  32'(key_held),  1);
    check("press_valid", 32'(key_valid), 1);
    check("press_code",  32'(key_code),  6);
    row = 4'b1111;
    repeat (10) tick();
    check("release_still_held", 32'(key_held), 1);
    repeat (2) tick();
    check("release_held", 32'(key_held), 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("single_event", 32'(key_valid), 0);

    // Bounce shorter than the debounce window.
    wait_col(2);
    row = 4'b1101;
    repeat (5) tick();
    row = 4'b1111;
    repeat (3) tick();
    check("bounce_col",   32'(col),       'h7);
    check("bounce_valid", 32'(key_valid), 0);
    check("bounce_held",  32'(key_held),  0);

    // Two rows low at once: ignored, scanning continues.
    wait_col(1);
    row = 4'b1001;
    repeat (12) tick();
    check("multi_col",   32'(col),       'hE);
    check("multi_valid", 32'(key_valid), 0);
    check("multi_held",  32'(key_held),  0);
    row = 4'b1111;

    // Auto-repeat on code 0.
    wait_col(0);
    row = 4'b1110;
    repeat_en = 1'b1;
    key_ready = 1'b1;
    nev = 0;
    ev_code0 = -1;
    for (int t = 0; t < 120; t++) begin
      tick();
      if (t == 81) row = 4'b1111;
      if (t == 70) check("rpt_held", 32'(key_held), 1);
      if (key_valid) begin
        if (nev == 0) ev_code0 = int'(key_code);
        if (nev < 8) ev_t[nev] = t;
        nev++;
      end
    end
    repeat_en = 1'b0;
    key_ready = 1'b0;
    check("rpt_count", 32'(nev), 4);
    check("rpt_code",  32'(ev_code0), 0);
    if (nev >= 4) begin
      check("rpt_d1", 32'(ev_t[1] - ev_t[0]), 32);
      check("rpt_d2", 32'(ev_t[2] - ev_t[0]), 48);
      check("rpt_d3", 32'(ev_t[3] - ev_t[0]), 64);
    end
    check("rpt_released", 32'(key_held), 0);

    // Queue fill with no consumer, then overflow.
    press(0, 1, 14);
    press(1, 2, 14);
    press(2, 3, 14);
    press(3, 0, 14);
    check("fill_ovf",   32'(overflow),  0);
    check("fill_valid", 32'(key_valid), 1);
    press(1, 1, 14);
    check("ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_code%0d", i), 32'(key_code), 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q%0d_valid", i), 32'(key_valid), 1);
      check($sformatf("q%0d_code", i),  32'(key_code),  32'(exp_codes[i]));
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
    end
    check("q_drained",   32'(key_valid), 0);
    check("ovf_sticky",  32'(overflow),  1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Reset in the middle of a press debounce.
    wait_col(2);
    row = 4'b1101;
    repeat (6) tick();
    rst = 1'b1;
    row = 4'b1111;
    tick();
    rst = 1'b0;
    check("abort_col",   32'(col),       'hF);
    check("abort_valid", 32'(key_valid), 0);
    check("abort_held",  32'(key_held),  0);
    tick();
    check("abort_restart_col", 32'(col), 'hE);
    repeat (20) tick();
    check("abort_no_event", 32'(key_valid), 0);
    check("abort_no_held",  32'(key_held),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 Parameter COLS, default 4, number of column drive outputs (2..8).
REQ-003 Parameter DWELL_CYC, default 50000, clocks each column is driven per scan step.
REQ-004 Parameter DB_CYC, default 500000, clocks of stable level required for press/release debounce.
REQ-005 Parameter RPT_DLY_CYC, default 25000000, hold time before the first auto-repeat.
REQ-006 Parameter RPT_PER_CYC, default 5000000, auto-repeat interval.
REQ-007 Parameter FIFO_DEPTH, default 4, key-event queue depth (power of 2, >=2).
REQ-008 Derived KW = clog2(ROWS*COLS), key-code width.
REQ-009 clk  in  1  system clock (50 MHz nominal); single clock domain.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 row  in  ROWS  asynchronous keypad rows, active-low, pulled high (all ones = no key).
REQ-012 repeat_en  in  1  enables auto-repeat while a key is held.
REQ-013 col  out  COLS  column drive, one-hot active-low during scan, registered.
REQ-014 key_code  out  KW  head-of-queue code = row_index*COLS + col_index.
REQ-015 key_valid  out  1  queue non-empty.
REQ-016 key_ready  in  1  consumer accepts key_code when key_valid&&key_ready.
REQ-017 key_held  out  1  a debounced key is currently down.
REQ-018 overflow  out  1  sticky: an event was dropped because the queue was full.

Function
REQ-019 row SHALL pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-020 States SCAN, DB_PRESS, HELD, DB_RELEASE; reset enters SCAN with column index 0.
REQ-021 SCAN: drive column c low for DWELL_CYC clocks, sample rows in the last clock; no row low -> advance c (COLS-1 wraps to 0).
REQ-022 SCAN sample with exactly one row low -> latch (row,c), hold column c, go DB_PRESS; two or more rows low -> treat as no key and advance.
REQ-023 DB_PRESS: latched row SHALL stay low, other rows high, for DB_CYC consecutive clocks; any deviation -> SCAN, advance column.
REQ-024 DB_PRESS completion -> push code, assert key_held, go HELD; key_valid high the next clock if queue was empty.
REQ-025 HELD: all rows high -> DB_RELEASE; repeat_en=1 pushes the code after RPT_DLY_CYC held clocks, then every RPT_PER_CYC clocks; repeat_en=0 clears the repeat timer.
REQ-026 DB_RELEASE: all rows high for DB_CYC clocks -> clear key_held, go SCAN at next column; latched row low again -> HELD with the repeat timer continuing.
REQ-027 Queue: FIFO order, key_code/key_valid from head; pop on key_valid&&key_ready.
REQ-028 Push when full SHALL drop the new code and set overflow; push and pop in the same clock when full SHALL both succeed.
REQ-029 overflow SHALL clear only on rst.
REQ-030 key_code SHALL hold stable while key_valid&&!key_ready.

Reset
REQ-031 rst (sampled on clk) SHALL give col = all ones, key_valid=0, key_held=0, overflow=0, queue empty, all timers 0, synchroniser all ones.
REQ-032 First clock after rst release SHALL drive col = ~1 (column 0 low).
REQ-033 rst mid-debounce or mid-hold SHALL abort with no event queued.

Structure
REQ-034 Shared package keypad_pkg SHALL hold the state encoding and default timing constants.
REQ-035 Queue SHALL be sub-module key_event_fifo (params WIDTH, DEPTH; push/pop/full/empty).
REQ-036 Timers SHALL be sized by clog2 of their largest parameter; no latches; outputs registered.

Verification (ROWS=COLS=4, DWELL_CYC=4, DB_CYC=8, RPT_DLY_CYC=32, RPT_PER_CYC=16, FIFO_DEPTH=4)
REQ-037 Reset release, row=4'b1111 -> col cycles 1110,1101,1011,0111 every 4 clocks, key_valid stays 0.
REQ-038 row=4'b1101 while column 2 driven, held 20 clocks -> one event code 6, key_held=1; release 8 clocks -> key_held=0.
REQ-039 row=4'b1101 for 5 clocks then 1111 -> no event, scanning resumes at column 3.
REQ-040 row=4'b1001 (two rows) -> no event, no lock.
REQ-041 repeat_en=1, key code 0 held 80 clocks after debounce -> events at +0,+32,+48,+64.
REQ-042 key_ready=0, 5 distinct presses -> first 4 codes in order, fifth dropped, overflow=1 until rst.
